// File: rtl/dna_readout_if.sv
// Register-bank read port of dna_readout: level request, word select,
// one-cycle acknowledge and held read data.
interface dna_readout_if;
    logic        req_i;
    logic [1:0]  addr_i;
    logic        ack_o;
    logic [31:0] data_o;

    modport master (output req_i, output addr_i, input ack_o, input data_o);
    modport slave  (input req_i, input addr_i, output ack_o, output data_o);
endinterface

// File: rtl/dna_readout.sv
// Qualifies, locks and serves the device DNA as 32-bit register words.
// Optional CRC-8 over the locked value: define DNA_READOUT_CRC_EN.
module dna_readout #(
    parameter int DNA_LENGTH    = 57,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DNA_LENGTH-1:0] dna_i,
    dna_readout_if.slave          bus,
    output logic                  dna_valid_o,
    output logic [DNA_LENGTH-1:0] dna_o,
    output logic [7:0]            crc_o
);

    typedef enum logic [1:0] {IDLE, QUALIFY, CRC, LOCKED} state_t;

    localparam logic [3:0]  LAST_STABLE = 4'(STABLE_CYCLES - 1);
    localparam logic [31:0] ID_WORD     = 32'hD1A0_0001;

    state_t                  state, state_n;
    logic [DNA_LENGTH-1:0]   held, held_n, dna_n;
    logic [3:0]              count, count_n;
    logic                    valid_n;
    logic                    req_q;
    logic                    req_edge;
    logic [63:0]             dna_ext;
    logic [31:0]             rd_data;

`ifdef DNA_READOUT_CRC_EN
    localparam logic [5:0] LAST_BIT = 6'(DNA_LENGTH - 1);

    logic [5:0] bit_cnt, bit_cnt_n;
    logic [7:0] crc_acc, crc_acc_n, crc_n, crc_step;

    // CRC-8, poly 0x07, MSB first, one message bit per call
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    always_comb begin
        state_n = state;
        held_n  = held;
        count_n = count;
        dna_n   = dna_o;
        valid_n = dna_valid_o;
`ifdef DNA_READOUT_CRC_EN
        bit_cnt_n = bit_cnt;
        crc_acc_n = crc_acc;
        crc_n     = crc_o;
        crc_step  = crc_acc;
`endif
        case (state)
            IDLE: begin
                if (dna_i != '0) begin
                    held_n  = dna_i;
                    count_n = 4'd1;
                    state_n = QUALIFY;
                end
            end
            QUALIFY: begin
                if (dna_i == '0) begin
                    count_n = 4'd0;
                    state_n = IDLE;
                end else if (dna_i != held) begin
                    held_n  = dna_i;
                    count_n = 4'd1;
                end else begin
                    count_n = count + 4'd1;
                    if (count == LAST_STABLE) begin
                        dna_n = held;
`ifdef DNA_READOUT_CRC_EN
                        bit_cnt_n = 6'd0;
                        crc_acc_n = 8'h00;
                        state_n   = CRC;
`else
                        valid_n = 1'b1;
                        state_n = LOCKED;
`endif
                    end
                end
            end
            CRC: begin
`ifdef DNA_READOUT_CRC_EN
                crc_step  = crc8_step(crc_acc, dna_o[LAST_BIT - bit_cnt]);
                crc_acc_n = crc_step;
                bit_cnt_n = bit_cnt + 6'd1;
                if (bit_cnt == LAST_BIT) begin
                    crc_n   = crc_step;
                    valid_n = 1'b1;
                    state_n = LOCKED;
                end
`else
                state_n = IDLE;
`endif
            end
            LOCKED: begin
                // dna_i is deliberately ignored once locked
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            held        <= '0;
            count       <= 4'd0;
            dna_o       <= '0;
            dna_valid_o <= 1'b0;
        end else begin
            state       <= state_n;
            held        <= held_n;
            count       <= count_n;
            dna_o       <= dna_n;
            dna_valid_o <= valid_n;
        end
    end

`ifdef DNA_READOUT_CRC_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt <= 6'd0;
            crc_acc <= 8'h00;
            crc_o   <= 8'h00;
        end else begin
            bit_cnt <= bit_cnt_n;
            crc_acc <= crc_acc_n;
            crc_o   <= crc_n;
        end
    end
`else
    assign crc_o = 8'h00;
`endif

    // Read port: registered mux of the current registers, one ack per req rising edge
    assign req_edge = bus.req_i & ~req_q;
    assign dna_ext  = 64'(dna_o);

    always_comb begin
        rd_data = 32'd0;
        case (bus.addr_i)
            2'd0: if (dna_valid_o) rd_data = dna_ext[31:0];
            2'd1: if (dna_valid_o) rd_data = dna_ext[63:32];
            2'd2: rd_data = {dna_valid_o, 23'd0, crc_o};
            2'd3: rd_data = ID_WORD;
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_q      <= 1'b0;
            bus.ack_o  <= 1'b0;
            bus.data_o <= 32'd0;
        end else begin
            req_q     <= bus.req_i;
            bus.ack_o <= req_edge;
            if (req_edge) bus.data_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_dna_readout.sv
// Bench for dna_readout: table-driven register reads through a scoreboard
// plus hand-written lock, glitch, handshake and reset sequences.
module tb_dna_readout;

    localparam int DNA_LENGTH = 57;
`ifdef DNA_READOUT_CRC_EN
    localparam int LAT = 4 + 57;
`else
    localparam int LAT = 4;
`endif
    localparam logic [31:0]           ID_WORD = 32'hD1A0_0001;
    localparam logic [DNA_LENGTH-1:0] DNA_A   = 57'h123456789abcdef;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [DNA_LENGTH-1:0] dna_i;
    logic                  dna_valid_o;
    logic [DNA_LENGTH-1:0] dna_o;
    logic [7:0]            crc_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    rd_vec_t     tbl[4];
    logic [7:0]  exp_crc;
    logic [31:0] exp_w2;
    int          acks;

    dna_readout_if bus();

    dna_readout #(.DNA_LENGTH(DNA_LENGTH), .STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .dna_i       (dna_i),
        .bus         (bus),
        .dna_valid_o (dna_valid_o),
        .dna_o       (dna_o),
        .crc_o       (crc_o)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] crc8_ref(input logic [56:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 56; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One read: expected word queued at request, popped when the ack appears
    task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        @(negedge clock);
        bus.req_i  = 1'b1;
        bus.addr_i = a;
        exp_q.push_back(exp);
        @(negedge clock);
        check({name, " ack"}, 64'(bus.ack_o), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.ack_o) check({name, " data"}, 64'(bus.data_o), 64'(e));
        end
        bus.req_i = 1'b0;
        @(negedge clock);
        check({name, " ack pulse"}, 64'(bus.ack_o), 64'd0);
    endtask

    task automatic run_table();
        for (int i = 0; i < 4; i++) do_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
    endtask

    task automatic wait_lock(input string name);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clock);
            if (k == LAT - 1) check({name, " valid early"}, 64'(dna_valid_o), 64'd0);
            if (k == LAT)     check({name, " valid on time"}, 64'(dna_valid_o), 64'd1);
        end
    endtask

    initial begin
`ifdef DNA_READOUT_CRC_EN
        exp_crc = crc8_ref(DNA_A);
`else
        exp_crc = 8'h00;
`endif
        exp_w2 = {1'b1, 23'd0, exp_crc};

        reset      = 1'b1;
        dna_i      = '0;
        bus.req_i  = 1'b0;
        bus.addr_i = 2'd0;
        repeat (3) @(negedge clock);
        check("reset ack", 64'(bus.ack_o), 64'd0);
        check("reset data", 64'(bus.data_o), 64'd0);
        check("reset valid", 64'(dna_valid_o), 64'd0);
        check("reset dna", 64'(dna_o), 64'd0);
        check("reset crc", 64'(crc_o), 64'd0);
        reset = 1'b0;

        repeat (100) @(negedge clock);
        check("idle valid", 64'(dna_valid_o), 64'd0);

        tbl[0] = '{2'd3, ID_WORD, "pre id"};
        tbl[1] = '{2'd0, 32'd0,   "pre w0"};
        tbl[2] = '{2'd1, 32'd0,   "pre w1"};
        tbl[3] = '{2'd2, 32'd0,   "pre w2"};
        run_table();

        // Clean step to a valid DNA
        dna_i = DNA_A;
        wait_lock("step");
        check("step dna", 64'(dna_o), 64'(DNA_A));
        check("step crc", 64'(crc_o), 64'(exp_crc));
        tbl[0] = '{2'd0, 32'h89abcdef, "lock w0"};
        tbl[1] = '{2'd1, 32'h01234567, "lock w1"};
        tbl[2] = '{2'd2, exp_w2,       "lock w2"};
        tbl[3] = '{2'd3, ID_WORD,      "lock id"};
        run_table();

        // Level request held high: exactly one ack, then a second after a low cycle
        @(negedge clock);
        bus.req_i  = 1'b1;
        bus.addr_i = 2'd3;
        exp_q.push_back(ID_WORD);
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.ack_o) begin
                acks++;
                if (exp_q.size() > 0) check("held req data", 64'(bus.data_o), 64'(exp_q.pop_front()));
            end
        end
        check("held req ack count", 64'(acks), 64'd1);
        exp_q.delete();
        bus.req_i = 1'b0;
        @(negedge clock);
        bus.req_i  = 1'b1;
        bus.addr_i = 2'd0;
        exp_q.push_back(32'h89abcdef);
        @(negedge clock);
        check("re-req ack", 64'(bus.ack_o), 64'd1);
        if (exp_q.size() > 0) check("re-req data", 64'(bus.data_o), 64'(exp_q.pop_front()));
        bus.req_i = 1'b0;
        @(negedge clock);

        // Glitchy reader output locks only to the final value; later zeros are ignored
        reset = 1'b1;
        dna_i = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        dna_i = 57'h1;
        @(negedge clock);
        dna_i = 57'h2;
        repeat (2) @(negedge clock);
        dna_i = DNA_A;
        wait_lock("glitch");
        check("glitch dna", 64'(dna_o), 64'(DNA_A));
        dna_i = '0;
        repeat (5) @(negedge clock);
        check("locked dna kept", 64'(dna_o), 64'(DNA_A));
        check("locked valid kept", 64'(dna_valid_o), 64'd1);
        do_read(2'd2, exp_w2, "glitch w2");
        do_read(2'd3, ID_WORD, "glitch id");

        // Reset mid-qualification / mid-CRC, then requalify from IDLE
        reset = 1'b1;
        dna_i = '0;
        @(negedge clock);
        reset = 1'b0;
        dna_i = DNA_A;
`ifdef DNA_READOUT_CRC_EN
        repeat (10) @(negedge clock);
`else
        repeat (2) @(negedge clock);
`endif
        reset = 1'b1;
        @(negedge clock);
        check("mid reset valid", 64'(dna_valid_o), 64'd0);
        check("mid reset dna", 64'(dna_o), 64'd0);
        check("mid reset crc", 64'(crc_o), 64'd0);
        check("mid reset ack", 64'(bus.ack_o), 64'd0);
        check("mid reset data", 64'(bus.data_o), 64'd0);
        reset = 1'b0;
        wait_lock("requalify");
        check("requalify dna", 64'(dna_o), 64'(DNA_A));
        check("requalify crc", 64'(crc_o), 64'(exp_crc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dna_readout.md
# dna_readout

Slow-control consumer of the 57-bit device DNA bus produced by the device DNA reader. It qualifies the DNA value, which reads all-zero while the reader is busy, until it is stable. It then locks the value, optionally computes a serial CRC-8 over it, and serves it to the register bank as 32-bit words through a request/acknowledge handshake.

## Interface
- DNA_LENGTH, 57, width of the DNA bus; legal range 33..64
- STABLE_CYCLES, 4, consecutive identical non-zero samples required before locking; legal range 2..15
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- dna_i  in  DNA_LENGTH  DNA from the reader; all-zero until its read completes
- req_i  in  1  read request from the register bank; level, edge-detected internally
- addr_i  in  2  word select, sampled on the cycle the req_i rising edge is detected
- ack_o  out  1  one-cycle acknowledge; data_o is valid while ack_o=1 and is held afterwards
- data_o  out  32  read data
- dna_valid_o  out  1  locked DNA, and CRC if compiled in, is available
- dna_o  out  DNA_LENGTH  locked DNA value
- crc_o  out  8  CRC-8 of the locked DNA; constant 0 without the macro

## Operation
- Reset values: ack_o=0, data_o=0, dna_valid_o=0, dna_o=0, crc_o=0, state IDLE, stability count 0, req edge register 0.
- Reset asserted in any state, including mid-qualification and mid-CRC, returns the block to these values on the next edge.
- FSM states and transitions:
  - IDLE: dna_i==0 stays in IDLE. On non-zero, capture held<=dna_i, count<=1, go to QUALIFY.
  - QUALIFY:
    - dna_i==0: go to IDLE, count<=0.
    - dna_i!=held and non-zero: held<=dna_i, count<=1, stay.
    - dna_i==held: count+1. If count==STABLE_CYCLES-1, dna_o<=held and go to CRC (macro) or LOCKED (no macro).
  - CRC: serial CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR. Feeds one bit per cycle, MSB first, bit DNA_LENGTH-1 down to bit 0. A 6-bit counter runs 0..DNA_LENGTH-1. On the last bit, crc_o<=result and go to LOCKED.
  - LOCKED: dna_valid_o=1. dna_i is ignored until reset; later changes, including zero, have no effect.
- Read map, with unused bits zero:
  - addr 0: dna_o[31:0].
  - addr 1: dna_o[DNA_LENGTH-1:32], zero-extended.
  - addr 2: bit31=dna_valid_o, bits 7:0=crc_o.
  - addr 3: constant 32'hD1A0_0001, an ID word.
- Reads are served in every state. Before lock, addr 0 and addr 1 return 0.

## Timing
- req edge = req_i & ~req_q, where req_q is req_i registered.
- ack_o=1 and data_o are updated on the edge after the edge is detected: one-cycle latency from the first sampled-high cycle of req_i.
- Holding req_i high produces exactly one ack. A new ack requires req_i low for at least one sampled cycle.
- Lock latency without the macro: dna_valid_o rises on the edge that samples the STABLE_CYCLES-th consecutive identical non-zero value. It is visible STABLE_CYCLES cycles after the first non-zero sample edge.
- Lock latency with the macro: DNA_LENGTH additional cycles. dna_o is updated at end of QUALIFY, crc_o and dna_valid_o on the same edge at end of CRC.
- A read that coincides with the locking edge returns the pre-lock values, since data_o is a registered mux of the current registers.

## Configuration
- DNA_READOUT_CRC_EN defined: the CRC state and crc logic are compiled in, and crc_o and addr 2 bits 7:0 carry the CRC.
- Not defined: the FSM goes QUALIFY->LOCKED directly, crc_o is tied 0, and addr 2 bits 7:0 read 0.

## Test plan
- Reset, then dna_i=0 for 100 cycles -> dna_valid_o=0. Read addr 3 -> data_o=32'hD1A0_0001 one cycle after the req edge, ack_o high exactly 1 cycle.
- dna_i steps 0 -> 57'h123456789abcdef and holds (no macro) -> dna_valid_o=1 exactly 4 cycles after the first non-zero sample. Addr 0 -> 32'h89abcdef, addr 1 -> 32'h01234567, addr 2 -> 32'h8000_0000.
- dna_i glitches 57'h1, then 57'h2 for 2 cycles, then 57'h123456789abcdef -> locks only to 57'h123456789abcdef, 4 cycles after its first sample. Afterwards drive dna_i=0 -> dna_o is unchanged.
- Macro defined, same DNA -> dna_valid_o rises 57 cycles later than the no-macro build. crc_o matches the bench CRC-8 (0x07) reference model, and addr 2 bits 7:0 equal crc_o.
- req_i held high 10 cycles -> one ack. Drop for 1 cycle and raise again -> second ack. Assert reset during CRC -> all outputs 0 next cycle, and qualification restarts from IDLE.
